// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint controller for the rename map table.
// Tracks NUM_CKPT snapshot slots. An age matrix records which slots were
// allocated after which, so a mispredict can squash a branch and all of its
// younger checkpoints, and drive a one-cycle restore of the map table.
module rename_ckpt_ctrl #(
   parameter int NUM_CKPT      = 4,
   parameter int NUM_ARCH_REGS = 32,
   parameter int PHYS_REG_BITS = 7,
   parameter int TAG_BITS      = $clog2(NUM_CKPT)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   alloc_req,
   output logic                                   alloc_ready,
   output logic [TAG_BITS-1:0]                    alloc_tag,
   input  logic [NUM_ARCH_REGS*PHYS_REG_BITS-1:0] mt_snapshot,
   output logic                                   ckpt_en,
   input  logic                                   resolve_valid,
   input  logic [TAG_BITS-1:0]                    resolve_tag,
   input  logic                                   resolve_mispredict,
   output logic                                   restore_en,
   output logic [NUM_ARCH_REGS*PHYS_REG_BITS-1:0] restore_table,
   output logic [NUM_CKPT-1:0]                    flush_mask,
   output logic [NUM_CKPT-1:0]                    ckpt_valid,
   output logic [TAG_BITS:0]                      num_used
);

   localparam int MT_W = NUM_ARCH_REGS * PHYS_REG_BITS;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RESTORE = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_CKPT-1:0] valid_q, valid_d;
   // younger_q[i][j] = 1 means slot j was allocated after slot i
   logic [NUM_CKPT-1:0] younger_q [NUM_CKPT];
   logic [NUM_CKPT-1:0] younger_d [NUM_CKPT];
   logic [MT_W-1:0]     slot_q [NUM_CKPT];
   logic [MT_W-1:0]     restore_table_q, restore_table_d;
   logic [NUM_CKPT-1:0] flush_mask_q, flush_mask_d;

   logic                free_found;
   logic [TAG_BITS-1:0] free_idx;
   logic                res_hit;
   logic                mispred_fire;
   logic [NUM_CKPT-1:0] free_mask;
   logic [NUM_CKPT-1:0] live_after_free;

   // Lowest-index invalid slot; defaults to 0 when nothing is free
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_CKPT - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = TAG_BITS'(i);
         end
      end
   end

   // Occupancy count of the registered valid bits
   always_comb begin
      num_used = '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
         num_used = num_used + (TAG_BITS + 1)'(valid_q[i]);
      end
   end

   // A mispredict in the same cycle blocks alloc: that branch would be squashed
   assign alloc_ready   = (state_q == ST_RUN) & free_found
                          & ~(resolve_valid & resolve_mispredict);
   assign ckpt_en       = alloc_req & alloc_ready;
   assign alloc_tag     = free_idx;
   assign restore_en    = (state_q == ST_RESTORE);
   assign restore_table = restore_table_q;
   assign flush_mask    = flush_mask_q;
   assign ckpt_valid    = valid_q;

   // Resolve decode: only resolves of occupied slots while running take effect
   always_comb begin
      res_hit      = resolve_valid & (state_q == ST_RUN) & valid_q[resolve_tag];
      mispred_fire = res_hit & resolve_mispredict;
      free_mask    = '0;
      if (res_hit) begin
         free_mask = NUM_CKPT'(1) << resolve_tag;
         if (resolve_mispredict) begin
            free_mask = free_mask | younger_q[resolve_tag];
         end
      end
      live_after_free = valid_q & ~free_mask;
   end

   // Next-state for the FSM, valid bits, age matrix and restore outputs
   always_comb begin
      state_d         = state_q;
      restore_table_d = restore_table_q;
      flush_mask_d    = '0;
      valid_d         = live_after_free;
      for (int i = 0; i < NUM_CKPT; i++) begin
         younger_d[i] = free_mask[i] ? '0 : (younger_q[i] & ~free_mask);
      end

      case (state_q)
         ST_RUN: begin
            if (mispred_fire) begin
               state_d         = ST_RESTORE;
               restore_table_d = slot_q[resolve_tag];
               flush_mask_d    = free_mask;
            end
         end
         ST_RESTORE: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase

      // Alloc and mispredict are mutually exclusive; alloc and correct resolve
      // touch different slots because the granted slot is currently invalid
      if (ckpt_en) begin
         valid_d[free_idx] = 1'b1;
         for (int j = 0; j < NUM_CKPT; j++) begin
            if (live_after_free[j]) begin
               younger_d[j][free_idx] = 1'b1;
            end
         end
         younger_d[free_idx] = '0;
      end
   end

   // Control state and restore outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RUN;
         valid_q         <= '0;
         restore_table_q <= '0;
         flush_mask_q    <= '0;
         for (int i = 0; i < NUM_CKPT; i++) begin
            younger_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         valid_q         <= valid_d;
         restore_table_q <= restore_table_d;
         flush_mask_q    <= flush_mask_d;
         for (int i = 0; i < NUM_CKPT; i++) begin
            younger_q[i] <= younger_d[i];
         end
      end
   end

   // Snapshot storage; contents are only meaningful while the slot is valid
   always_ff @(posedge clk) begin
      if (ckpt_en) begin
         slot_q[free_idx] <= mt_snapshot;
      end
   end

endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Self-checking bench for rename_ckpt_ctrl: directed scenarios with literal
// expectations, then randomized traffic against an allocation-order model.
module tb_rename_ckpt_ctrl;

   localparam int MT_W = 32 * 7;

   logic            clk;
   logic            rst;
   logic            alloc_req;
   logic            alloc_ready;
   logic [1:0]      alloc_tag;
   logic [MT_W-1:0] mt_snapshot;
   logic            ckpt_en;
   logic            resolve_valid;
   logic [1:0]      resolve_tag;
   logic            resolve_mispredict;
   logic            restore_en;
   logic [MT_W-1:0] restore_table;
   logic [3:0]      flush_mask;
   logic [3:0]      ckpt_valid;
   logic [2:0]      num_used;

   rename_ckpt_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .alloc_req          (alloc_req),
      .alloc_ready        (alloc_ready),
      .alloc_tag          (alloc_tag),
      .mt_snapshot        (mt_snapshot),
      .ckpt_en            (ckpt_en),
      .resolve_valid      (resolve_valid),
      .resolve_tag        (resolve_tag),
      .resolve_mispredict (resolve_mispredict),
      .restore_en         (restore_en),
      .restore_table      (restore_table),
      .flush_mask         (flush_mask),
      .ckpt_valid         (ckpt_valid),
      .num_used           (num_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: each occupied slot remembers its allocation sequence number;
   // "younger" simply means a larger sequence number.
   bit              m_valid [4];
   int unsigned     m_seq [4];
   logic [MT_W-1:0] m_slot [4];
   int unsigned     seq_ctr = 0;
   bit              m_restore = 0;
   logic [3:0]      m_flush = '0;
   logic [MT_W-1:0] m_rtab = '0;

   // Observed DUT outputs of the most recent step
   logic            obs_ready, obs_ckpt_en, obs_restore_en;
   logic [1:0]      obs_tag;
   logic [3:0]      obs_flush, obs_valid;
   logic [2:0]      obs_used;
   logic [MT_W-1:0] obs_rtab;

   task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [MT_W-1:0] rand_snap();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom()};
   endfunction

   // Drive one cycle of inputs, compare all outputs to the model, advance model
   task automatic step(input bit r, input bit req, input bit rv, input logic [1:0] rt,
                       input bit rm, input logic [MT_W-1:0] snap);
      int         cnt;
      int         low;
      bit         exp_ready;
      logic [3:0] vbits;
      @(negedge clk);
      rst                = r;
      alloc_req          = req;
      resolve_valid      = rv;
      resolve_tag        = rt;
      resolve_mispredict = rm;
      mt_snapshot        = snap;
      #1;
      cnt   = 0;
      low   = -1;
      vbits = '0;
      for (int i = 3; i >= 0; i--) begin
         if (m_valid[i]) begin
            cnt++;
            vbits[i] = 1'b1;
         end else begin
            low = i;
         end
      end
      exp_ready = !m_restore && (cnt < 4) && !(rv && rm);
      cmp("alloc_ready", 256'(alloc_ready), 256'(exp_ready));
      cmp("ckpt_en", 256'(ckpt_en), 256'(req && exp_ready));
      if (cnt < 4) cmp("alloc_tag", 256'(alloc_tag), 256'(low));
      cmp("restore_en", 256'(restore_en), 256'(m_restore));
      cmp("flush_mask", 256'(flush_mask), 256'(m_restore ? m_flush : 4'b0));
      if (m_restore) cmp("restore_table", 256'(restore_table), 256'(m_rtab));
      cmp("ckpt_valid", 256'(ckpt_valid), 256'(vbits));
      cmp("num_used", 256'(num_used), 256'(cnt));

      obs_ready      = alloc_ready;
      obs_ckpt_en    = ckpt_en;
      obs_restore_en = restore_en;
      obs_tag        = alloc_tag;
      obs_flush      = flush_mask;
      obs_valid      = ckpt_valid;
      obs_used       = num_used;
      obs_rtab       = restore_table;

      if (r) begin
         for (int i = 0; i < 4; i++) m_valid[i] = 0;
         m_restore = 0;
         m_flush   = '0;
         m_rtab    = '0;
      end else begin
         bit was_restore;
         was_restore = m_restore;
         m_restore   = 0;
         m_flush     = '0;
         if (!was_restore && rv && m_valid[rt]) begin
            if (rm) begin
               int unsigned s;
               s = m_seq[rt];
               for (int i = 0; i < 4; i++) begin
                  if (m_valid[i] && m_seq[i] >= s) begin
                     m_flush[i] = 1'b1;
                     m_valid[i] = 0;
                  end
               end
               m_restore = 1;
               m_rtab    = m_slot[rt];
            end else begin
               m_valid[rt] = 0;
            end
         end
         if (req && exp_ready) begin
            m_valid[low] = 1;
            m_seq[low]   = seq_ctr;
            m_slot[low]  = snap;
            seq_ctr++;
         end
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 2'd0, 0, rand_snap());
   endtask

   task automatic alloc();
      step(0, 1, 0, 2'd0, 0, rand_snap());
   endtask

   task automatic do_reset();
      step(1, 0, 0, 2'd0, 0, rand_snap());
   endtask

   logic [MT_W-1:0] snap_a;
   bit              r_r, r_req, r_rv, r_rm;
   logic [1:0]      r_rt;

   initial begin
      rst = 1'b1; alloc_req = 0; resolve_valid = 0; resolve_tag = '0;
      resolve_mispredict = 0; mt_snapshot = '0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0; m_seq[i] = 0; m_slot[i] = '0;
      end

      // Scenario 1: reset state, then three allocs
      do_reset();
      alloc();
      cmp("t1_rst_valid", 256'(obs_valid), 256'(4'b0000));
      cmp("t1_rst_used", 256'(obs_used), 256'(0));
      cmp("t1_rst_restore_en", 256'(obs_restore_en), 256'(0));
      cmp("t1_rst_flush", 256'(obs_flush), 256'(0));
      cmp("t1_rst_rtab", 256'(obs_rtab), 256'(0));
      cmp("t1_tag0", 256'(obs_tag), 256'(0));
      alloc();
      cmp("t1_tag1", 256'(obs_tag), 256'(1));
      alloc();
      cmp("t1_tag2", 256'(obs_tag), 256'(2));
      idle();
      cmp("t1_valid", 256'(obs_valid), 256'(4'b0111));
      cmp("t1_used", 256'(obs_used), 256'(3));

      // Scenario 2: fill, stall while full, free tag 1 and reuse it
      alloc();
      cmp("t2_tag3", 256'(obs_tag), 256'(3));
      alloc();
      cmp("t2_full_ready", 256'(obs_ready), 256'(0));
      cmp("t2_full_ckpt_en", 256'(obs_ckpt_en), 256'(0));
      step(0, 1, 1, 2'd1, 0, rand_snap());
      cmp("t2_full_ready2", 256'(obs_ready), 256'(0));
      alloc();
      cmp("t2_reuse_ready", 256'(obs_ready), 256'(1));
      cmp("t2_reuse_tag", 256'(obs_tag), 256'(1));

      // Scenario 3: mispredict on the oldest branch restores its snapshot
      do_reset();
      snap_a = rand_snap();
      snap_a[34:28] = 7'd60;
      step(0, 1, 0, 2'd0, 0, snap_a);
      alloc();
      alloc();
      step(0, 0, 1, 2'd0, 1, rand_snap());
      idle();
      cmp("t3_restore_en", 256'(obs_restore_en), 256'(1));
      cmp("t3_x4", 256'(obs_rtab[34:28]), 256'(60));
      cmp("t3_flush", 256'(obs_flush), 256'(4'b0111));
      idle();
      cmp("t3_valid_after", 256'(obs_valid), 256'(0));
      cmp("t3_restore_done", 256'(obs_restore_en), 256'(0));

      // Scenario 4: out-of-order resolve, then a stale mispredict
      do_reset();
      alloc(); alloc(); alloc();
      step(0, 0, 1, 2'd0, 0, rand_snap());
      step(0, 0, 1, 2'd1, 1, rand_snap());
      idle();
      cmp("t4_flush", 256'(obs_flush), 256'(4'b0110));
      step(0, 0, 1, 2'd0, 1, rand_snap());
      cmp("t4_valid", 256'(obs_valid), 256'(0));
      idle();
      cmp("t4_stale_ignored", 256'(obs_restore_en), 256'(0));

      // Scenario 5: alloc blocked by same-cycle mispredict and by RESTORE
      do_reset();
      alloc();
      step(0, 1, 1, 2'd0, 1, rand_snap());
      cmp("t5_same_ckpt_en", 256'(obs_ckpt_en), 256'(0));
      cmp("t5_same_ready", 256'(obs_ready), 256'(0));
      alloc();
      cmp("t5_restore_ready", 256'(obs_ready), 256'(0));
      alloc();
      cmp("t5_after_ckpt_en", 256'(obs_ckpt_en), 256'(1));
      cmp("t5_after_tag", 256'(obs_tag), 256'(0));

      // Scenario 6: reset during RESTORE
      do_reset();
      alloc(); alloc();
      step(0, 0, 1, 2'd0, 1, rand_snap());
      do_reset();
      cmp("t6_in_restore", 256'(obs_restore_en), 256'(1));
      alloc();
      cmp("t6_restore_en", 256'(obs_restore_en), 256'(0));
      cmp("t6_valid", 256'(obs_valid), 256'(0));
      cmp("t6_tag", 256'(obs_tag), 256'(0));
      cmp("t6_ready", 256'(obs_ready), 256'(1));

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r_r   = ($urandom_range(0, 199) == 0);
         r_req = ($urandom_range(0, 99) < 60);
         r_rv  = ($urandom_range(0, 99) < 40);
         r_rt  = 2'($urandom_range(0, 3));
         r_rm  = ($urandom_range(0, 99) < 25);
         step(r_r, r_req, r_rv, r_rt, r_rm, rand_snap());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
